// File: rtl/tensor_host_sequencer.sv
// Host-side job sequencer for the tensor CPU: burst-writes two 3x3 int8 matrices,
// issues one operate, waits for writeback and burst-reads the 3x3 result.
module tensor_host_sequencer #(
  parameter int OPERATE_WAIT_CYCLES = 6
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic [2:0]  op_select_in,
  input  logic [71:0] matrix1_in,
  input  logic [71:0] matrix2_in,
  input  logic [7:0]  cpu_output_in,
  output logic [15:0] instruction_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [71:0] result_out
);

  localparam logic [15:0] INSTR_NOP   = 16'h0000;
  localparam logic [15:0] BURST_WRITE = 16'h0007;
  localparam logic [15:0] BURST_READ  = 16'h0003;
  localparam int          WAIT_W      = $clog2(OPERATE_WAIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(OPERATE_WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WRITE_CMD, S_WRITE_BEAT, S_OP_CMD,
    S_OP_WAIT, S_READ_CMD, S_READ_BEAT, S_DONE
  } state_t;

  state_t              state_q;
  logic [15:0]         instr_q;
  logic                busy_q;
  logic                done_q;
  logic [159:0]        buf_q;
  logic [2:0]          op_q;
  logic [2:0]          beat_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [63:0]         rbuf_q;
  logic [7:0]          stage_q;
  logic [71:0]         result_q;

  logic [7:0]          beat_base;
  logic [31:0]         beat_bytes;

  // Four consecutive buffer bytes 4k..4k+3 feed the two DDR phases of write beat k.
  assign beat_base  = {beat_q, 5'b00000};
  assign beat_bytes = buf_q[beat_base +: 32];

  always_comb begin
    instruction_out = instr_q;
    if (state_q == S_WRITE_BEAT) begin
      instruction_out = clock_in ? {beat_bytes[7:0], beat_bytes[15:8]}
                                 : {beat_bytes[23:16], beat_bytes[31:24]};
    end
  end

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign result_out = result_q;

  // Even result elements arrive mid-beat; they are parked here and committed on the posedge.
  always_ff @(negedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      stage_q <= 8'h00;
    end else if (state_q == S_READ_BEAT) begin
      stage_q <= cpu_output_in;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      instr_q  <= INSTR_NOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      buf_q    <= '0;
      op_q     <= 3'd0;
      beat_q   <= 3'd0;
      wait_q   <= '0;
      rbuf_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_q <= INSTR_NOP;
          if (start_in) begin
            buf_q   <= {16'h0000, matrix2_in, matrix1_in};
            op_q    <= op_select_in;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          instr_q <= BURST_WRITE;
          state_q <= S_WRITE_CMD;
        end
        S_WRITE_CMD: begin
          instr_q <= INSTR_NOP;
          beat_q  <= 3'd0;
          state_q <= S_WRITE_BEAT;
        end
        S_WRITE_BEAT: begin
          if (beat_q == 3'd4) begin
            instr_q <= {11'b0, op_q, 2'b10};
            state_q <= S_OP_CMD;
          end else begin
            beat_q <= beat_q + 3'd1;
          end
        end
        // Operate is held for exactly one cycle; a longer hold would restart the CPU timer.
        S_OP_CMD: begin
          instr_q <= INSTR_NOP;
          wait_q  <= WAIT_LOAD;
          state_q <= S_OP_WAIT;
        end
        S_OP_WAIT: begin
          if (wait_q == '0) begin
            instr_q <= BURST_READ;
            state_q <= S_READ_CMD;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        S_READ_CMD: begin
          instr_q <= INSTR_NOP;
          beat_q  <= 3'd0;
          state_q <= S_READ_BEAT;
        end
        S_READ_BEAT: begin
          if (beat_q == 3'd4) begin
            result_q <= {stage_q, rbuf_q};
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end else begin
            rbuf_q[{beat_q[1:0], 4'b0000} +: 16] <= {cpu_output_in, stage_q};
            beat_q <= beat_q + 3'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          instr_q <= INSTR_NOP;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_host_sequencer.sv
// Testbench for tensor_host_sequencer: timeline model of a full job, directed tables,
// random jobs, held start, mid-job reset and a longer operate wait.
module tb_tensor_host_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r;
  logic        sel;
  logic [2:0]  op_r;
  logic [71:0] m1_r, m2_r;
  logic [7:0]  cpu_in;

  logic        start6, start9;
  logic [15:0] instr6, instr9;
  logic        busy6, busy9, done6, done9;
  logic [71:0] res6, res9;

  logic [15:0] obs_instr;
  logic        obs_busy, obs_done;
  logic [71:0] obs_res;

  assign start6    = start_r & ~sel;
  assign start9    = start_r & sel;
  assign obs_instr = sel ? instr9 : instr6;
  assign obs_busy  = sel ? busy9 : busy6;
  assign obs_done  = sel ? done9 : done6;
  assign obs_res   = sel ? res9 : res6;

  tensor_host_sequencer dut (
    .clock_in(clk), .reset_in(rst), .start_in(start6), .op_select_in(op_r),
    .matrix1_in(m1_r), .matrix2_in(m2_r), .cpu_output_in(cpu_in),
    .instruction_out(instr6), .busy_out(busy6), .done_out(done6), .result_out(res6)
  );

  tensor_host_sequencer #(.OPERATE_WAIT_CYCLES(9)) dut9 (
    .clock_in(clk), .reset_in(rst), .start_in(start9), .op_select_in(op_r),
    .matrix1_in(m1_r), .matrix2_in(m2_r), .cpu_output_in(cpu_in),
    .instruction_out(instr9), .busy_out(busy9), .done_out(done9), .result_out(res9)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_hi [64];
  logic [15:0] exp_lo [64];
  logic        exp_busy [64];
  logic        exp_done [64];
  int          exp_len;
  logic [15:0] trace_hi [64];
  logic [15:0] trace_lo [64];
  logic        trace_done [64];
  logic [7:0]  cpu_el [10];

  typedef struct {
    int          cyc;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        done;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected bus timeline of one job, counted in cycles after the start posedge.
  task automatic model_job(input logic [71:0] m1, input logic [71:0] m2,
                           input logic [2:0] op, input int n);
    logic [7:0] b [20];
    for (int e = 0; e < 9; e++) begin
      b[e]     = m1[8*e +: 8];
      b[9 + e] = m2[8*e +: 8];
    end
    b[18] = 8'h00;
    b[19] = 8'h00;
    exp_len = 15 + n;
    for (int c = 0; c < exp_len; c++) begin
      exp_hi[c]   = 16'h0000;
      exp_lo[c]   = 16'h0000;
      exp_busy[c] = 1'b1;
      exp_done[c] = 1'b0;
      if (c == 1) begin
        exp_hi[c] = 16'h0007;
        exp_lo[c] = 16'h0007;
      end else if (c >= 2 && c <= 6) begin
        exp_hi[c] = {b[4*(c-2)], b[4*(c-2)+1]};
        exp_lo[c] = {b[4*(c-2)+2], b[4*(c-2)+3]};
      end else if (c == 7) begin
        exp_hi[c] = {11'b0, op, 2'b10};
        exp_lo[c] = {11'b0, op, 2'b10};
      end else if (c == 8 + n) begin
        exp_hi[c] = 16'h0003;
        exp_lo[c] = 16'h0003;
      end
      if (c == 14 + n) begin
        exp_busy[c] = 1'b0;
        exp_done[c] = 1'b1;
      end
    end
  endtask

  // Call at posedge+1 with the selected DUT idle; cpu_el holds the CPU's result elements.
  task automatic run_job(input logic [71:0] m1, input logic [71:0] m2,
                         input logic [2:0] op, input bit use9, input string tag);
    int n;
    int kk;
    logic [71:0] exp_res;
    n = use9 ? 9 : 6;
    model_job(m1, m2, op, n);
    for (int e = 0; e < 9; e++) exp_res[8*e +: 8] = cpu_el[e];
    sel = use9; m1_r = m1; m2_r = m2; op_r = op; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    for (int c = 0; c < exp_len; c++) begin
      kk = c - (9 + n);
      trace_hi[c]   = obs_instr;
      trace_done[c] = obs_done;
      chk($sformatf("%s c%0d instr_hi", tag, c), 72'(obs_instr), 72'(exp_hi[c]));
      chk($sformatf("%s c%0d busy", tag, c), 72'(obs_busy), 72'(exp_busy[c]));
      chk($sformatf("%s c%0d done", tag, c), 72'(obs_done), 72'(exp_done[c]));
      if (exp_done[c]) chk($sformatf("%s c%0d result", tag, c), obs_res, exp_res);
      cpu_in = (kk >= 0 && kk <= 4) ? cpu_el[2*kk] : 8'($urandom);
      @(negedge clk); #1;
      trace_lo[c] = obs_instr;
      chk($sformatf("%s c%0d instr_lo", tag, c), 72'(obs_instr), 72'(exp_lo[c]));
      cpu_in = (kk >= 0 && kk <= 4) ? cpu_el[2*kk+1] : 8'($urandom);
      @(posedge clk); #1;
    end
    chk({tag, " idle busy"}, 72'(obs_busy), 72'(0));
    chk({tag, " idle done"}, 72'(obs_done), 72'(0));
    chk({tag, " held result"}, obs_res, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] m1, m2;
    logic [95:0] r;
    logic signed [7:0] sv [9];
    int ops, prev_op, d1, d2, nd;

    tbl[0]  = '{0,  16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1,  16'h0007, 16'h0007, 1'b0};
    tbl[2]  = '{2,  16'h0102, 16'h0304, 1'b0};
    tbl[3]  = '{3,  16'h0506, 16'h0708, 1'b0};
    tbl[4]  = '{4,  16'h0901, 16'h0000, 1'b0};
    tbl[5]  = '{5,  16'h0001, 16'h0000, 1'b0};
    tbl[6]  = '{6,  16'h0001, 16'h0000, 1'b0};
    tbl[7]  = '{7,  16'h0002, 16'h0002, 1'b0};
    tbl[8]  = '{8,  16'h0000, 16'h0000, 1'b0};
    tbl[9]  = '{13, 16'h0000, 16'h0000, 1'b0};
    tbl[10] = '{14, 16'h0003, 16'h0003, 1'b0};
    tbl[11] = '{19, 16'h0000, 16'h0000, 1'b0};
    tbl[12] = '{20, 16'h0000, 16'h0000, 1'b1};

    rst = 1'b1; start_r = 1'b0; sel = 1'b0; op_r = 3'd0;
    m1_r = '0; m2_r = '0; cpu_in = 8'h00;
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("reset%0d instr", s), 72'(obs_instr), 72'(0));
      chk($sformatf("reset%0d busy", s), 72'(obs_busy), 72'(0));
      chk($sformatf("reset%0d done", s), 72'(obs_done), 72'(0));
      chk($sformatf("reset%0d result", s), obs_res, 72'(0));
    end
    sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed job: matrix1 = 1..9, matrix2 = identity, CPU returns 0x10+e.
    for (int e = 0; e < 10; e++) cpu_el[e] = 8'(8'h10 + e);
    run_job(72'h090807060504030201, 72'h010000000100000001, 3'd0, 1'b0, "dir");
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl c%0d hi", tbl[i].cyc), 72'(trace_hi[tbl[i].cyc]), 72'(tbl[i].hi));
      chk($sformatf("tbl c%0d lo", tbl[i].cyc), 72'(trace_lo[tbl[i].cyc]), 72'(tbl[i].lo));
      chk($sformatf("tbl c%0d done", tbl[i].cyc), 72'(trace_done[tbl[i].cyc]), 72'(tbl[i].done));
    end
    chk("dir result", res6, 72'h181716151413121110);

    // Signed extremes travel as raw bytes.
    sv = '{-8'sd128, 8'sd127, -8'sd1, 8'sd1, 8'sd0, 8'sd64, -8'sd64, 8'sd5, -8'sd5};
    for (int e = 0; e < 9; e++) m1[8*e +: 8] = sv[e];
    for (int e = 0; e < 10; e++) cpu_el[e] = 8'($urandom);
    run_job(m1, 72'h0, 3'd5, 1'b0, "signed");
    chk("signed beat0 hi", 72'(trace_hi[2]), 72'(16'h807F));
    chk("signed beat0 lo", 72'(trace_lo[2]), 72'(16'hFF01));
    chk("signed operate", 72'(trace_hi[7]), 72'(16'h0016));

    for (int j = 0; j < 6; j++) begin
      r = {$urandom, $urandom, $urandom}; m1 = r[71:0];
      r = {$urandom, $urandom, $urandom}; m2 = r[71:0];
      for (int e = 0; e < 10; e++) cpu_el[e] = 8'($urandom);
      run_job(m1, m2, 3'($urandom_range(0, 7)), (j >= 4), $sformatf("rnd%0d", j));
    end

    // Longer operate wait shifts the read command and done by three cycles.
    for (int e = 0; e < 10; e++) cpu_el[e] = 8'(8'h20 + e);
    run_job(72'h090807060504030201, 72'h010000000100000001, 3'd1, 1'b1, "wait9");
    chk("wait9 read_cmd c17", 72'(trace_hi[17]), 72'(16'h0003));
    chk("wait9 done c23", 72'(trace_done[23]), 72'(1));
    chk("wait9 result", res9, 72'h282726252423222120);

    // start_in held high: back-to-back jobs separated by DONE and one IDLE cycle.
    sel = 1'b0; m1_r = {9{8'h55}}; m2_r = {9{8'h55}}; op_r = 3'd3; start_r = 1'b1;
    @(posedge clk); #1;
    ops = 0; prev_op = 0; d1 = -1; d2 = -1; nd = 0;
    for (int c = 0; c < 44; c++) begin
      cpu_in = 8'($urandom);
      chk($sformatf("hold c%0d busy", c), 72'(busy6),
          72'(!(c == 20 || c == 21 || c == 42 || c == 43)));
      chk($sformatf("hold c%0d busy&done", c), 72'(busy6 & done6), 72'(0));
      if (instr6 == 16'h000E) begin
        ops++;
        chk($sformatf("hold c%0d operate repeat", c), 72'(prev_op), 72'(0));
        prev_op = 1;
      end else begin
        prev_op = 0;
      end
      if (done6) begin
        if (nd == 0) d1 = c; else d2 = c;
        nd++;
      end
      if (c == 43) start_r = 1'b0;
      @(posedge clk); #1;
    end
    chk("hold first done", 72'(d1), 72'(20));
    chk("hold second done", 72'(d2), 72'(42));
    chk("hold operate count", 72'(ops), 72'(2));

    // Asynchronous reset in the middle of write beat 2.
    m1_r = 72'h090807060504030201; m2_r = 72'h010000000100000001; op_r = 3'd2;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("midrst beat2 hi", 72'(instr6), 72'(16'h0901));
    #1 rst = 1'b1;
    #1;
    chk("midrst instr", 72'(instr6), 72'(0));
    chk("midrst busy", 72'(busy6), 72'(0));
    chk("midrst result", res6, 72'(0));
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst instr", 72'(instr6), 72'(0));
    chk("postrst busy", 72'(busy6), 72'(0));
    for (int e = 0; e < 10; e++) cpu_el[e] = 8'($urandom);
    r = {$urandom, $urandom, $urandom};
    run_job(r[71:0], 72'h0102030405060708F0, 3'd7, 1'b0, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tensor_host_sequencer.md
Name: tensor_host_sequencer

Overview:
- Host-side driver for the 16-bit instruction bus and 8-bit result bus of the tensor CPU.
- Takes two 3x3 signed 8-bit matrices and an operation select, then runs one complete job:
  - burst-writes both matrices;
  - issues one tensor-core operate;
  - waits for writeback;
  - burst-reads the 3x3 result.
- Used by the board top level and the system testbench in place of hand-written instruction streams.

Parameters:
- OPERATE_WAIT_CYCLES, 6, number of NOP cycles between the operate instruction and the burst read (min 6).

Ports:
- clock_in  input  1  system clock, same clock as the CPU.
- reset_in  input  1  asynchronous, active-high reset.
- start_in  input  1  begin a job; sampled on posedge only while idle.
- op_select_in  input  3  matrix operation select, placed in instruction[4:2] of the operate word.
- matrix1_in  input  72  element e (row e/3, col e%3) in bits [8e+7:8e].
- matrix2_in  input  72  same packing as matrix1_in.
- cpu_output_in  input  8  CPU result bus.
- instruction_out  output  16  CPU current_instruction.
- busy_out  output  1  high from the posedge after start until done.
- done_out  output  1  one-cycle pulse; result_out is valid from this cycle onward.
- result_out  output  72  result matrix, same packing as the inputs; held until the next done.

Behaviour:
- Reset, asynchronous: state=IDLE, instruction_out=16'h0000 (generic NOP), busy_out=0, done_out=0, result_out=0, all internal latches cleared.
- Reset mid-job: abort immediately to IDLE with no further instructions. The CPU's own burst counter self-terminates after 5 beats.
- Instruction words:
  - opcode is bits [1:0]: GENERIC=00, LOAD_IMM=01, OPERATE=10, BURST=11.
  - BURST select is bits [3:2]: READ=00, WRITE=01.
  - BURST_WRITE=16'h0007, BURST_READ=16'h0003, OPERATE={11'b0, op_select, 2'b10}, NOP=16'h0000.
  - The sequencer must never emit 16'h000C (generic reset) outside write beats.
- Start: start_in=1 at posedge S while IDLE latches matrix1_in, matrix2_in and op_select_in into a 20-byte buffer.
  - Byte b<9 is matrix1 element b; bytes 9..17 are matrix2 elements 0..8; bytes 18 and 19 are 0.
  - busy_out goes to 1. start_in while busy is ignored.
- State sequence, with entry posedge for the default wait of 6:
  - WRITE_CMD (S+1): drive BURST_WRITE for 1 cycle.
  - WRITE_BEAT k=0..4 (S+2..S+6): 5 cycles, double-data-rate drive from the clock level.
    - While clock_in=1: instruction_out={byte4k, byte4k+1}; the CPU latches these on the negedge.
    - While clock_in=0: instruction_out={byte4k+2, byte4k+3}; the CPU latches these on the next posedge.
    - instruction_out is a clock-level mux only in this state; every other state drives from a register.
  - OP_CMD (S+7): drive OPERATE for exactly 1 cycle. Holding it longer restarts the CPU timer and is forbidden.
  - OP_WAIT (S+8): drive NOP for OPERATE_WAIT_CYCLES cycles, counted by a down-counter.
  - READ_CMD (S+8+N): drive BURST_READ for 1 cycle.
  - READ_BEAT k=0..4 (S+9+N..): 5 cycles, drive NOP.
    - On the negedge inside beat k, capture cpu_output_in as element 2k.
    - On the posedge ending beat k, capture element 2k+1.
    - Element 9 (beat 4, posedge) is discarded.
    - The negedge capture goes into a single staging register; all result writes happen on posedge.
  - DONE (S+14+N): done_out=1 and busy_out=0 for 1 cycle, result_out updated, then IDLE.
- Default end-to-end: start posedge S to done posedge S+20.
- Beat counter is 3 bits and saturates at 4, then exits the state. There is no wrap-around.

Test Plan:
- Start with matrix1 = 1..9, matrix2 = identity, op_select=0 -> instruction_out sequence:
  - 0x0007;
  - 5 beats whose high/low phases are {01,02}/{03,04}, ..., {11-byte?}; exact bytes are listed in the bench table; last low phase is {00,00};
  - 0x0002;
  - 6 x 0x0000;
  - 0x0003;
  - done_out pulses at S+20.
- Reader check: cpu_output_in model drives 0x10+e for element e (even elements in the high phase, odd in the low phase) -> result_out = 0x18,0x17,...,0x10 packed top-down; element 9 is not stored.
- start_in held high continuously -> second job begins only after done; busy_out is never high in the DONE cycle; no OPERATE word is driven for 2 consecutive cycles.
- Reset asserted mid-WRITE_BEAT 2 (asynchronously, between edges) -> instruction_out=0x0000, busy_out=0 immediately; a new start after release completes normally.
- OPERATE_WAIT_CYCLES=9 -> READ_CMD moves 3 cycles later and done_out appears at S+23.
- Signed values: matrix elements -128 and 127 -> write bytes 0x80 and 0x7F appear unchanged on the bus.
